fetch_pc_predictor: RTL and testbench
=====================================

// Module: fetch_pc_predictor
// PURPOSE
//  Instruction-fetch front end. Holds the PC and drives the synchronous-read instruction
//  memory address. Predicts branches with a direct-mapped BTB and 2-bit saturating counters.
//  Produces if_pc / if_pred_taken for the IF/ID register. Accepts stall and EX-stage
//  redirect/update; sits directly upstream of IF/ID.
// PARAMETERS
//  RESET_PC  32'h00000000  PC value loaded on reset
//  ENTRIES   16            BTB entries; power of 2, >=2; IDX_W = log2(ENTRIES)
// PORTS
//  clk               in   1   clock
//  rst               in   1   asynchronous, active-high reset
//  pipeline_en       in   1   1 = advance PC; 0 = hold (stall)
//  ex_redirect       in   1   EX mispredict: fetch restarts at ex_redirect_pc
//  ex_redirect_pc    in   32  correct next PC from EX
//  ex_update_valid   in   1   resolved branch/jump in EX; train the BTB
//  ex_update_pc      in   32  PC of the resolved branch/jump
//  ex_actual_taken   in   1   resolved direction
//  ex_actual_target  in   32  resolved target
//  imem_addr         out  32  next_pc (combinational); IMEM registers it internally
//  if_pc             out  32  PC whose instruction IMEM presents this cycle (= pc_reg)
//  if_pred_taken     out  1   prediction made for if_pc
// BEHAVIOUR
//  - Index = pc[IDX_W+1:2]. Tag = pc[31:IDX_W+2]. Entry = {valid, tag, target[31:0], ctr[1:0]}.
//  - Lookup is combinational on pc_reg.
//    - hit = valid && tag match; pred_taken = hit && ctr[1].
//    - pred_target = entry target.
//  - next_pc priority:
//    1. ex_redirect -> ex_redirect_pc. Overrides stall.
//    2. !pipeline_en -> pc_reg.
//    3. pred_taken -> pred_target.
//    4. Otherwise pc_reg + 4, wrapping modulo 2^32.
//  - Every cycle: pc_reg <= next_pc; pred_reg <= pred_taken, or 0 when ex_redirect.
//    if_pc = pc_reg; if_pred_taken = pred_reg.
//  - Latency: IMEM output in cycle n+1 is the instruction at imem_addr from cycle n, which is
//    pc_reg in cycle n+1. Instruction, if_pc and if_pred_taken stay aligned with 0 extra
//    cycles.
//  - Stall: imem_addr = pc_reg, so the IMEM data, if_pc and if_pred_taken all hold.
//  - Training: on posedge, when ex_update_valid, at the index of ex_update_pc:
//    - taken, entry hit: target <= actual_target; ctr saturating +1 (max 2'b11).
//    - taken, miss: allocate. valid = 1, tag, target, ctr = 2'b10 (weakly taken).
//    - not taken, hit: ctr saturating -1 (min 2'b00); entry stays valid.
//    - not taken, miss: no change.
//  - Simultaneous lookup and update to the same index: the lookup sees the pre-update
//    contents. The update is visible from the next cycle.
//  - Training is independent of pipeline_en and ex_redirect; it still occurs while stalled.
//  - Reset (asynchronous, any cycle, including mid-stall or mid-redirect):
//    - pc_reg = RESET_PC; pred_reg = 0.
//    - All valid bits = 0; ctr = 2'b01. Target/tag values are don't-care.
//    - While rst is high, imem_addr = RESET_PC and if_pred_taken = 0.
//  - First cycle after rst deasserts: imem_addr = RESET_PC + 4 (BTB empty);
//    if_pc = RESET_PC.
// TESTING
//  T1 Reset: RESET_PC=0, run 3 cycles, no events -> if_pc 0,4,8; if_pred_taken 0; imem_addr
//     leads if_pc by +4.
//  T2 Train/predict: update pc=0x10, taken, target=0x40 -> when pc_reg reaches 0x10:
//     if_pred_taken=1, imem_addr=0x40, next if_pc=0x40.
//  T3 Counter saturation: 3 taken updates, then 2 not-taken updates on 0x10 -> ctr
//     10->11->11->10->01; final lookup of 0x10 predicts not taken, next_pc=0x14.
//  T4 Redirect during stall: pipeline_en=0, ex_redirect=1, redirect_pc=0x200 -> next
//     if_pc=0x200, if_pred_taken=0; 0x200 still held while the stall persists.
//  T5 Aliasing, ENTRIES=16: entry for 0x10 trained; lookup at 0x50 (same index, different
//     tag) -> miss, next_pc=0x54.
//  T6 Async reset mid-stream at pc=0x40 with a redirect pending -> outputs reset
//     immediately; after release, the earlier BTB entry for 0x10 no longer predicts.

Source files
------------

// File: rtl/fetch_pc_predictor_if.sv
// Fetch front-end bundle: EX-side control/training in, IMEM address and IF/ID stage values out.
// master = pipeline/EX side driving the predictor, slave = the predictor itself.
interface fetch_pc_predictor_if;
    logic        pipeline_en;
    logic        ex_redirect;
    logic [31:0] ex_redirect_pc;
    logic        ex_update_valid;
    logic [31:0] ex_update_pc;
    logic        ex_actual_taken;
    logic [31:0] ex_actual_target;
    logic [31:0] imem_addr;
    logic [31:0] if_pc;
    logic        if_pred_taken;

    modport master (
        output pipeline_en,
        output ex_redirect,
        output ex_redirect_pc,
        output ex_update_valid,
        output ex_update_pc,
        output ex_actual_taken,
        output ex_actual_target,
        input  imem_addr,
        input  if_pc,
        input  if_pred_taken
    );

    modport slave (
        input  pipeline_en,
        input  ex_redirect,
        input  ex_redirect_pc,
        input  ex_update_valid,
        input  ex_update_pc,
        input  ex_actual_taken,
        input  ex_actual_target,
        output imem_addr,
        output if_pc,
        output if_pred_taken
    );
endinterface

// File: rtl/fetch_pc_predictor.sv
// Fetch PC generator with direct-mapped BTB + 2-bit counters; imem_addr is next_pc, if_pc/if_pred_taken registered.
// Latency: 0 extra cycles vs. the synchronous IMEM; backpressure: pipeline_en=0 holds PC unless EX redirects.
module fetch_pc_predictor #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          ENTRIES  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    fetch_pc_predictor_if.slave  fp
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = 32 - IDX_W - 2;

    logic [31:0] pc_reg;
    logic        pred_reg;
    logic [31:0] next_pc;

    // BTB storage; only valid/counter need a reset value
    logic             btb_vld [ENTRIES];
    logic [1:0]       btb_ctr [ENTRIES];
    logic [TAG_W-1:0] btb_tag [ENTRIES];
    logic [31:0]      btb_tgt [ENTRIES];

    // Lookup on the current PC
    logic [IDX_W-1:0] lk_idx;
    logic [TAG_W-1:0] lk_tag;
    logic             lk_hit;
    logic             pred_taken;
    logic [31:0]      pred_target;

    assign lk_idx      = pc_reg[IDX_W+1:2];
    assign lk_tag      = pc_reg[31:IDX_W+2];
    assign lk_hit      = btb_vld[lk_idx] && (btb_tag[lk_idx] == lk_tag);
    assign pred_taken  = lk_hit && btb_ctr[lk_idx][1];
    assign pred_target = btb_tgt[lk_idx];

    always_comb begin
        next_pc = pc_reg + 32'd4;
        if (fp.ex_redirect) begin
            next_pc = fp.ex_redirect_pc;
        end else if (!fp.pipeline_en) begin
            next_pc = pc_reg;
        end else if (pred_taken) begin
            next_pc = pred_target;
        end
    end

    // IMEM must see RESET_PC for the whole reset window, whatever EX is driving
    assign fp.imem_addr     = rst ? RESET_PC : next_pc;
    assign fp.if_pc         = pc_reg;
    assign fp.if_pred_taken = pred_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_reg   <= RESET_PC;
            pred_reg <= 1'b0;
        end else begin
            pc_reg   <= next_pc;
            pred_reg <= fp.ex_redirect ? 1'b0 : pred_taken;
        end
    end

    // Training port, independent of stall/redirect
    logic [IDX_W-1:0] up_idx;
    logic [TAG_W-1:0] up_tag;
    logic             up_hit;
    logic [1:0]       up_ctr;
    logic [1:0]       ctr_inc;
    logic [1:0]       ctr_dec;
    logic             unused_up_pc_lsb;

    assign up_idx           = fp.ex_update_pc[IDX_W+1:2];
    assign up_tag           = fp.ex_update_pc[31:IDX_W+2];
    assign up_hit           = btb_vld[up_idx] && (btb_tag[up_idx] == up_tag);
    assign up_ctr           = btb_ctr[up_idx];
    assign ctr_inc          = (up_ctr == 2'b11) ? 2'b11 : up_ctr + 2'b01;
    assign ctr_dec          = (up_ctr == 2'b00) ? 2'b00 : up_ctr - 2'b01;
    assign unused_up_pc_lsb = ^fp.ex_update_pc[1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                btb_vld[i] <= 1'b0;
                btb_ctr[i] <= 2'b01;
            end
        end else if (fp.ex_update_valid) begin
            if (fp.ex_actual_taken) begin
                btb_vld[up_idx] <= 1'b1;
                btb_ctr[up_idx] <= up_hit ? ctr_inc : 2'b10;
            end else if (up_hit) begin
                btb_ctr[up_idx] <= ctr_dec;
            end
        end
    end

    // Tag/target are qualified by valid, so they carry no reset
    always_ff @(posedge clk) begin
        if (fp.ex_update_valid && fp.ex_actual_taken) begin
            btb_tag[up_idx] <= up_tag;
            btb_tgt[up_idx] <= fp.ex_actual_target;
        end
    end
endmodule

// File: tb/tb_fetch_pc_predictor.sv
// Directed bench for fetch_pc_predictor (RESET_PC=0, ENTRIES=16) with hand-computed expectations.
module tb_fetch_pc_predictor;
    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    fetch_pc_predictor_if bus ();

    fetch_pc_predictor #(
        .RESET_PC (32'h0000_0000),
        .ENTRIES  (16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .fp  (bus.slave)
    );

    task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One-cycle redirect so the following cycle looks up pc
    task automatic redirect_to(input logic [31:0] pc);
        bus.ex_redirect    = 1'b1;
        bus.ex_redirect_pc = pc;
        step();
        bus.ex_redirect    = 1'b0;
        #1;
    endtask

    // Train one entry while redirecting to look_pc in the same cycle
    task automatic train_look(input logic [31:0] upc, input logic taken,
                              input logic [31:0] tgt, input logic [31:0] look_pc);
        bus.ex_update_valid  = 1'b1;
        bus.ex_update_pc     = upc;
        bus.ex_actual_taken  = taken;
        bus.ex_actual_target = tgt;
        bus.ex_redirect      = 1'b1;
        bus.ex_redirect_pc   = look_pc;
        step();
        bus.ex_update_valid  = 1'b0;
        bus.ex_redirect      = 1'b0;
        #1;
    endtask

    initial begin
        rst                  = 1'b1;
        bus.pipeline_en      = 1'b1;
        bus.ex_redirect      = 1'b0;
        bus.ex_redirect_pc   = 32'h0;
        bus.ex_update_valid  = 1'b0;
        bus.ex_update_pc     = 32'h0;
        bus.ex_actual_taken  = 1'b0;
        bus.ex_actual_target = 32'h0;
        #1;
        chk_val("rst_imem", bus.imem_addr, 32'h0);
        chk_val("rst_pc", bus.if_pc, 32'h0);
        chk_val("rst_pred", {31'h0, bus.if_pred_taken}, 32'h0);
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        #1;
        // T1: sequential fetch after reset
        chk_val("t1_pc0", bus.if_pc, 32'h0);
        chk_val("t1_imem0", bus.imem_addr, 32'h4);
        step();
        chk_val("t1_pc1", bus.if_pc, 32'h4);
        chk_val("t1_imem1", bus.imem_addr, 32'h8);
        step();
        chk_val("t1_pc2", bus.if_pc, 32'h8);
        chk_val("t1_imem2", bus.imem_addr, 32'hC);
        chk_val("t1_pred2", {31'h0, bus.if_pred_taken}, 32'h0);

        // T2: train 0x10 -> 0x40, then reach it sequentially
        bus.ex_update_valid  = 1'b1;
        bus.ex_update_pc     = 32'h10;
        bus.ex_actual_taken  = 1'b1;
        bus.ex_actual_target = 32'h40;
        step();
        bus.ex_update_valid  = 1'b0;
        #1;
        chk_val("t2_pc_c", bus.if_pc, 32'hC);
        chk_val("t2_imem_c", bus.imem_addr, 32'h10);
        step();
        chk_val("t2_pc_10", bus.if_pc, 32'h10);
        chk_val("t2_imem_pred", bus.imem_addr, 32'h40);
        step();
        chk_val("t2_pc_40", bus.if_pc, 32'h40);
        chk_val("t2_pred_reg", {31'h0, bus.if_pred_taken}, 32'h1);
        chk_val("t2_imem_44", bus.imem_addr, 32'h44);

        // T3: counter 10->11->11->10->01->00->00->01->10
        train_look(32'h10, 1'b1, 32'h40, 32'h10);
        chk_val("t3_ctr11a", bus.imem_addr, 32'h40);
        chk_val("t3_redir_pred", {31'h0, bus.if_pred_taken}, 32'h0);
        train_look(32'h10, 1'b1, 32'h40, 32'h10);
        chk_val("t3_ctr11b", bus.imem_addr, 32'h40);
        train_look(32'h10, 1'b0, 32'h0, 32'h10);
        chk_val("t3_ctr10", bus.imem_addr, 32'h40);
        train_look(32'h10, 1'b0, 32'h0, 32'h10);
        chk_val("t3_ctr01", bus.imem_addr, 32'h14);
        step();
        chk_val("t3_pc14", bus.if_pc, 32'h14);
        chk_val("t3_pred14", {31'h0, bus.if_pred_taken}, 32'h0);
        train_look(32'h10, 1'b0, 32'h0, 32'h10);
        chk_val("t3_ctr00a", bus.imem_addr, 32'h14);
        train_look(32'h10, 1'b0, 32'h0, 32'h10);
        chk_val("t3_ctr00b", bus.imem_addr, 32'h14);
        train_look(32'h10, 1'b1, 32'h80, 32'h10);
        chk_val("t3_ctr01_up", bus.imem_addr, 32'h14);
        train_look(32'h10, 1'b1, 32'h80, 32'h10);
        chk_val("t3_ctr10_tgt", bus.imem_addr, 32'h80);

        // T4: redirect during stall while 0x10 is predicting taken
        bus.pipeline_en    = 1'b0;
        bus.ex_redirect    = 1'b1;
        bus.ex_redirect_pc = 32'h200;
        step();
        bus.ex_redirect    = 1'b0;
        #1;
        chk_val("t4_pc", bus.if_pc, 32'h200);
        chk_val("t4_pred", {31'h0, bus.if_pred_taken}, 32'h0);
        chk_val("t4_imem", bus.imem_addr, 32'h200);
        step();
        step();
        chk_val("t4_hold_pc", bus.if_pc, 32'h200);
        chk_val("t4_hold_imem", bus.imem_addr, 32'h200);
        bus.pipeline_en = 1'b1;
        #1;
        chk_val("t4_resume_imem", bus.imem_addr, 32'h204);
        step();
        chk_val("t4_resume_pc", bus.if_pc, 32'h204);

        // T5: alias 0x50 shares index with 0x10
        redirect_to(32'h50);
        chk_val("t5_alias_miss", bus.imem_addr, 32'h54);
        bus.ex_update_valid = 1'b1;
        bus.ex_update_pc    = 32'h50;
        bus.ex_actual_taken = 1'b0;
        step();
        bus.ex_update_valid = 1'b0;
        redirect_to(32'h10);
        chk_val("t5_nt_miss_nochg", bus.imem_addr, 32'h80);

        // Same-cycle lookup and update see pre-update contents
        redirect_to(32'h60);
        bus.ex_update_valid  = 1'b1;
        bus.ex_update_pc     = 32'h60;
        bus.ex_actual_taken  = 1'b1;
        bus.ex_actual_target = 32'h100;
        #1;
        chk_val("same_idx_old", bus.imem_addr, 32'h64);
        step();
        bus.ex_update_valid = 1'b0;
        redirect_to(32'h60);
        chk_val("same_idx_new", bus.imem_addr, 32'h100);

        // T6: async reset mid-cycle at pc 0x40 with a redirect pending
        redirect_to(32'h40);
        bus.ex_redirect    = 1'b1;
        bus.ex_redirect_pc = 32'h300;
        #2 rst = 1'b1;
        #1;
        chk_val("t6_async_pc", bus.if_pc, 32'h0);
        chk_val("t6_async_imem", bus.imem_addr, 32'h0);
        chk_val("t6_async_pred", {31'h0, bus.if_pred_taken}, 32'h0);
        @(posedge clk);
        #2;
        chk_val("t6_held_pc", bus.if_pc, 32'h0);
        chk_val("t6_held_imem", bus.imem_addr, 32'h0);
        bus.ex_redirect = 1'b0;
        #1 rst = 1'b0;
        #1;
        chk_val("t6_rel_pc", bus.if_pc, 32'h0);
        chk_val("t6_rel_imem", bus.imem_addr, 32'h4);
        redirect_to(32'h10);
        chk_val("t6_btb_clr10", bus.imem_addr, 32'h14);
        redirect_to(32'h60);
        chk_val("t6_btb_clr60", bus.imem_addr, 32'h64);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
